// File: rtl/axi_chk_pkg.sv
// Shared definitions for the AXI protocol checker: error bit indices,
// the read-queue entry layout and the first-error priority helper.
package axi_chk_pkg;

  localparam int ERR_WLAST   = 0;
  localparam int ERR_W_NO_AW = 1;
  localparam int ERR_B_NO_W  = 2;
  localparam int ERR_RLAST   = 3;
  localparam int ERR_R_NO_AR = 4;
  localparam int ERR_RID     = 5;
  localparam int ERR_STABLE  = 6;
  localparam int ERR_OVF     = 7;
  localparam int ERR_NUM     = 8;

  // Read-queue fields are sized for the widest supported ID/LEN; narrower
  // bus fields are zero-extended on push and on compare.
  localparam int RD_ID_MAX_W  = 16;
  localparam int RD_LEN_MAX_W = 8;

  typedef struct packed {
    logic [RD_ID_MAX_W-1:0]  id;
    logic [RD_LEN_MAX_W-1:0] len;
  } rd_entry_t;

  function automatic logic [2:0] first_set(input logic [ERR_NUM-1:0] v);
    first_set = '0;
    for (int i = ERR_NUM - 1; i >= 0; i--) begin
      if (v[i]) first_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/axi_chk_fifo.sv
// Synchronous FIFO with a combinational head; when empty, a same-cycle
// push shows through on head and a push+pop passes without being stored.
module axi_chk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
  logic             wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign head  = empty ? din : mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    wr_en    = push && !(empty && pop) && (!full || pop);
    rd_en    = pop && !empty;
    wr_ptr_d = wr_ptr_q + (IDX_W+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (IDX_W+1)'(rd_en);
    mem_d    = mem_q;
    if (wr_en) mem_d[wr_ptr_q[IDX_W-1:0]] = din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axi_protocol_checker.sv
// Passive AXI checker: tracks bursts against AW/AR lengths, checks handshake
// stability and response ordering, and latches sticky error flags.
module axi_protocol_checker
  import axi_chk_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 4,
  parameter int MAX_OUTST = 8,
  parameter int RID_CHECK = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           awvalid,
  input  logic                           awready,
  input  logic                           arvalid,
  input  logic                           arready,
  input  logic                           wvalid,
  input  logic                           wready,
  input  logic                           wlast,
  input  logic                           bvalid,
  input  logic                           bready,
  input  logic                           rvalid,
  input  logic                           rready,
  input  logic                           rlast,
  input  logic [ADDR_W-1:0]              awaddr,
  input  logic [ADDR_W-1:0]              araddr,
  input  logic [ID_W-1:0]                awid,
  input  logic [ID_W-1:0]                arid,
  input  logic [ID_W-1:0]                bid,
  input  logic [ID_W-1:0]                rid,
  input  logic [LEN_W-1:0]               awlen,
  input  logic [LEN_W-1:0]               arlen,
  output logic [7:0]                     err,
  output logic [2:0]                     first_err,
  output logic                           err_any,
  output logic [31:0]                    wr_done_cnt,
  output logic [31:0]                    rd_done_cnt,
  output logic [$clog2(MAX_OUTST):0]     wr_outst,
  output logic [$clog2(MAX_OUTST):0]     rd_outst
);

  localparam int OUTST_W = $clog2(MAX_OUTST) + 1;

  logic aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic w_avail, w_beat, w_pop, w_push, aw_ovf;
  logic r_beat, r_pop, ar_push, ar_ovf, b_ok;
  logic wf_full, wf_empty, rf_full, rf_empty;
  logic [LEN_W-1:0] wf_head;
  rd_entry_t        rf_head, rf_din;
  logic [ERR_NUM-1:0] err_new;
  logic stable_bad;

  logic [LEN_W-1:0]   w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic [15:0]        b_pend_q, b_pend_d;
  logic [ERR_NUM-1:0] err_q, err_d;
  logic [2:0]         first_err_q, first_err_d;
  logic               err_any_q, err_any_d;
  logic [31:0]        wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic [OUTST_W-1:0] wr_outst_q, wr_outst_d, rd_outst_q, rd_outst_d;

  logic               aw_stall_q, aw_stall_d, ar_stall_q, ar_stall_d;
  logic               w_stall_q, w_stall_d, b_stall_q, b_stall_d, r_stall_q, r_stall_d;
  logic [ADDR_W-1:0]  aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [ID_W-1:0]    aw_id_q, aw_id_d, ar_id_q, ar_id_d;
  logic [LEN_W-1:0]   aw_len_q, aw_len_d, ar_len_q, ar_len_d;

  // B is matched by count only; its ID carries no check.
  logic unused_bid;
  assign unused_bid = ^bid;

  assign aw_hs = awvalid && awready;
  assign ar_hs = arvalid && arready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign r_hs  = rvalid && rready;

  assign w_avail = !wf_empty || aw_hs;
  assign w_beat  = w_hs && w_avail;
  assign w_pop   = w_beat && wlast;
  assign w_push  = aw_hs && (!wf_full || w_pop);
  assign aw_ovf  = aw_hs && wf_full && !w_pop;

  assign r_beat  = r_hs && !rf_empty;
  assign r_pop   = r_beat && rlast;
  assign ar_push = ar_hs && (!rf_full || r_pop);
  assign ar_ovf  = ar_hs && rf_full && !r_pop;
  assign b_ok    = b_hs && (b_pend_q != '0);

  assign rf_din = '{id: RD_ID_MAX_W'(arid), len: RD_LEN_MAX_W'(arlen)};

  axi_chk_fifo #(.WIDTH(LEN_W), .DEPTH(MAX_OUTST)) u_wr_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_push),
    .pop   (w_pop),
    .din   (awlen),
    .head  (wf_head),
    .full  (wf_full),
    .empty (wf_empty)
  );

  axi_chk_fifo #(.WIDTH($bits(rd_entry_t)), .DEPTH(MAX_OUTST)) u_rd_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (ar_push),
    .pop   (r_pop),
    .din   (rf_din),
    .head  (rf_head),
    .full  (rf_full),
    .empty (rf_empty)
  );

  always_comb begin
    aw_stall_d = awvalid && !awready;
    ar_stall_d = arvalid && !arready;
    w_stall_d  = wvalid && !wready;
    b_stall_d  = bvalid && !bready;
    r_stall_d  = rvalid && !rready;
    aw_addr_d  = awaddr;
    aw_id_d    = awid;
    aw_len_d   = awlen;
    ar_addr_d  = araddr;
    ar_id_d    = arid;
    ar_len_d   = arlen;

    stable_bad = (aw_stall_q && (!awvalid || awaddr != aw_addr_q ||
                                 awid != aw_id_q || awlen != aw_len_q)) ||
                 (ar_stall_q && (!arvalid || araddr != ar_addr_q ||
                                 arid != ar_id_q || arlen != ar_len_q)) ||
                 (w_stall_q && !wvalid) || (b_stall_q && !bvalid) ||
                 (r_stall_q && !rvalid);

    err_new              = '0;
    err_new[ERR_WLAST]   = w_beat && (wlast != (w_cnt_q == wf_head));
    err_new[ERR_W_NO_AW] = w_hs && !w_avail;
    err_new[ERR_B_NO_W]  = b_hs && (b_pend_q == '0);
    err_new[ERR_RLAST]   = r_beat && (rlast != (RD_LEN_MAX_W'(r_cnt_q) == rf_head.len));
    err_new[ERR_R_NO_AR] = r_hs && rf_empty;
    err_new[ERR_RID]     = (RID_CHECK != 0) && r_beat && (RD_ID_MAX_W'(rid) != rf_head.id);
    err_new[ERR_STABLE]  = stable_bad;
    err_new[ERR_OVF]     = aw_ovf || ar_ovf;

    w_cnt_d = w_cnt_q;
    if (w_beat) w_cnt_d = wlast ? '0 : w_cnt_q + 1'b1;
    r_cnt_d = r_cnt_q;
    if (r_beat) r_cnt_d = rlast ? '0 : r_cnt_q + 1'b1;

    b_pend_d   = b_pend_q + 16'(w_pop) - 16'(b_ok);
    wr_outst_d = wr_outst_q + OUTST_W'(w_push) - OUTST_W'(b_ok);
    rd_outst_d = rd_outst_q + OUTST_W'(ar_push) - OUTST_W'(r_pop);
    wr_done_d  = wr_done_q + 32'(b_ok);
    rd_done_d  = rd_done_q + 32'(r_pop);

    err_d       = err_q | err_new;
    err_any_d   = |err_d;
    first_err_d = first_err_q;
    if (err_q == '0 && err_new != '0) first_err_d = first_set(err_new);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_cnt_q     <= '0;
      r_cnt_q     <= '0;
      b_pend_q    <= '0;
      err_q       <= '0;
      first_err_q <= '0;
      err_any_q   <= 1'b0;
      wr_done_q   <= '0;
      rd_done_q   <= '0;
      wr_outst_q  <= '0;
      rd_outst_q  <= '0;
      aw_stall_q  <= 1'b0;
      ar_stall_q  <= 1'b0;
      w_stall_q   <= 1'b0;
      b_stall_q   <= 1'b0;
      r_stall_q   <= 1'b0;
      aw_addr_q   <= '0;
      aw_id_q     <= '0;
      aw_len_q    <= '0;
      ar_addr_q   <= '0;
      ar_id_q     <= '0;
      ar_len_q    <= '0;
    end else begin
      w_cnt_q     <= w_cnt_d;
      r_cnt_q     <= r_cnt_d;
      b_pend_q    <= b_pend_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      err_any_q   <= err_any_d;
      wr_done_q   <= wr_done_d;
      rd_done_q   <= rd_done_d;
      wr_outst_q  <= wr_outst_d;
      rd_outst_q  <= rd_outst_d;
      aw_stall_q  <= aw_stall_d;
      ar_stall_q  <= ar_stall_d;
      w_stall_q   <= w_stall_d;
      b_stall_q   <= b_stall_d;
      r_stall_q   <= r_stall_d;
      aw_addr_q   <= aw_addr_d;
      aw_id_q     <= aw_id_d;
      aw_len_q    <= aw_len_d;
      ar_addr_q   <= ar_addr_d;
      ar_id_q     <= ar_id_d;
      ar_len_q    <= ar_len_d;
    end
  end

  assign err         = err_q;
  assign first_err   = first_err_q;
  assign err_any     = err_any_q;
  assign wr_done_cnt = wr_done_q;
  assign rd_done_cnt = rd_done_q;
  assign wr_outst    = wr_outst_q;
  assign rd_outst    = rd_outst_q;

endmodule

// File: tb/tb_axi_protocol_checker.sv
// Directed bench for axi_protocol_checker with hand-computed expectations.
module tb_axi_protocol_checker;

  logic        clk = 1'b0;
  logic        rstn;
  logic        awvalid, awready, arvalid, arready, wvalid, wready, wlast;
  logic        bvalid, bready, rvalid, rready, rlast;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awid, arid, bid, rid, awlen, arlen;
  logic [7:0]  err;
  logic [2:0]  first_err;
  logic        err_any;
  logic [31:0] wr_done_cnt, rd_done_cnt;
  logic [3:0]  wr_outst, rd_outst;

  int n_vec = 0;
  int n_err = 0;

  axi_protocol_checker dut (
    .clk(clk), .rstn(rstn),
    .awvalid(awvalid), .awready(awready), .arvalid(arvalid), .arready(arready),
    .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .awaddr(awaddr), .araddr(araddr), .awid(awid), .arid(arid), .bid(bid), .rid(rid),
    .awlen(awlen), .arlen(arlen),
    .err(err), .first_err(first_err), .err_any(err_any),
    .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt),
    .wr_outst(wr_outst), .rd_outst(rd_outst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    awvalid = 0; awready = 0; arvalid = 0; arready = 0;
    wvalid = 0; wready = 0; wlast = 0; bvalid = 0; bready = 0;
    rvalid = 0; rready = 0; rlast = 0;
  endtask

  // apply current inputs across one rising edge, sample 1 ns later, then idle
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    rstn = 0;
    step();
    rstn = 1;
  endtask

  task automatic set_aw(input logic [3:0] len);
    awvalid = 1; awready = 1; awlen = len;
  endtask

  task automatic set_w(input logic last);
    wvalid = 1; wready = 1; wlast = last;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [3:0] len);
    arvalid = 1; arready = 1; arid = id; arlen = len;
  endtask

  task automatic set_r(input logic [3:0] id, input logic last);
    rvalid = 1; rready = 1; rid = id; rlast = last;
  endtask

  task automatic set_b();
    bvalid = 1; bready = 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".err"}, 32'(err), 0);
    chk({tag, ".first_err"}, 32'(first_err), 0);
    chk({tag, ".err_any"}, 32'(err_any), 0);
    chk({tag, ".wr_done"}, wr_done_cnt, 0);
    chk({tag, ".rd_done"}, rd_done_cnt, 0);
    chk({tag, ".wr_outst"}, 32'(wr_outst), 0);
    chk({tag, ".rd_outst"}, 32'(rd_outst), 0);
  endtask

  initial begin
    awaddr = 32'h1000; araddr = 32'h2000; awid = 0; bid = 0; arlen = 0; awlen = 0;
    arid = 0; rid = 0;
    do_reset();
    chk_all_zero("reset");

    // 4-beat write burst, then B
    set_aw(4'd3); step();
    chk("wr4.outst_aw", 32'(wr_outst), 1);
    for (int i = 0; i < 4; i++) begin
      set_w(i == 3); step();
    end
    set_b(); step();
    chk("wr4.err", 32'(err), 0);
    chk("wr4.done", wr_done_cnt, 1);
    chk("wr4.outst", 32'(wr_outst), 0);

    // AW + single-beat W bypass on empty FIFO, then AW alongside B
    set_aw(4'd0); set_w(1'b1); step();
    chk("byp.outst", 32'(wr_outst), 1);
    set_aw(4'd0); set_b(); step();
    chk("byp.err", 32'(err), 0);
    chk("byp.done", wr_done_cnt, 2);
    chk("byp.outst_net", 32'(wr_outst), 1);

    // missing WLAST on beat 2 of a 2-beat burst
    do_reset();
    set_aw(4'd1); step();
    set_w(1'b0); step();
    chk("wlast.beat1", 32'(err), 0);
    set_w(1'b0); step();
    chk("wlast.err", 32'(err), 32'h01);
    chk("wlast.first", 32'(first_err), 0);
    chk("wlast.any", 32'(err_any), 1);

    // RID mismatch on a single-beat read
    do_reset();
    set_ar(4'd5, 4'd0); step();
    chk("rid.outst_ar", 32'(rd_outst), 1);
    set_r(4'd3, 1'b1); step();
    chk("rid.err", 32'(err), 32'h20);
    chk("rid.first", 32'(first_err), 5);
    chk("rid.done", rd_done_cnt, 1);
    chk("rid.outst", 32'(rd_outst), 0);

    // AW address changes while stalled
    do_reset();
    awvalid = 1; awready = 0; awaddr = 32'h1000; awlen = 2; step();
    chk("stab.first_stall", 32'(err), 0);
    awvalid = 1; awready = 0; awaddr = 32'h1004; awlen = 2; step();
    chk("stab.err", 32'(err), 32'h40);
    chk("stab.first", 32'(first_err), 6);

    // read FIFO fill, push+pop on full, then overflow
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_ar(4'(i), 4'd0); step();
    end
    chk("ovf.full_outst", 32'(rd_outst), 8);
    chk("ovf.full_err", 32'(err), 0);
    set_ar(4'd8, 4'd0); set_r(4'd0, 1'b1); step();
    chk("ovf.pushpop_err", 32'(err), 0);
    chk("ovf.pushpop_outst", 32'(rd_outst), 8);
    chk("ovf.pushpop_done", rd_done_cnt, 1);
    set_ar(4'd9, 4'd0); step();
    chk("ovf.err", 32'(err), 32'h80);
    chk("ovf.first", 32'(first_err), 7);
    chk("ovf.outst", 32'(rd_outst), 8);

    // B with no write, then reset mid-burst
    do_reset();
    set_b(); step();
    chk("bnow.err", 32'(err), 32'h04);
    chk("bnow.first", 32'(first_err), 2);
    set_aw(4'd3); step();
    set_w(1'b0); step();
    set_w(1'b0); step();
    do_reset();
    chk_all_zero("midrst");
    set_w(1'b1); step();
    chk("postrst.err", 32'(err), 32'h02);
    chk("postrst.first", 32'(first_err), 1);

    // two errors in one cycle: lowest index wins
    do_reset();
    set_w(1'b1); set_r(4'd0, 1'b1); step();
    chk("multi.err", 32'(err), 32'h12);
    chk("multi.first", 32'(first_err), 1);

    // B in the same cycle as the WLAST it answers is early
    do_reset();
    set_aw(4'd0); step();
    set_w(1'b1); set_b(); step();
    chk("bsame.err", 32'(err), 32'h04);
    chk("bsame.done0", wr_done_cnt, 0);
    set_b(); step();
    chk("bsame.done", wr_done_cnt, 1);
    chk("bsame.outst", 32'(wr_outst), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_protocol_checker.md
# axi_protocol_checker

Passive, synthesizable AXI protocol checker that sits beside the AXI interface and samples all five channels on every rising edge without driving any bus signal. It counts write and read bursts through their handshakes and checks beat counts against the AW/AR lengths. It also checks VALID/payload stability and response ordering, raising sticky, registered error flags for the UVM scoreboard and for silicon debug. It is the parametrised, self-checking successor to the monitor-only sampling interface.

## Interface
Parameters:
- ADDR_W, 32, AW/AR address width
- ID_W, 4, AWID/ARID/BID/RID width
- LEN_W, 4, AWLEN/ARLEN width; burst length = len+1
- MAX_OUTST, 8, write and read outstanding-burst depth; power of two, ≥2
- RID_CHECK, 1, 1 = each R beat must carry the ARID at the head of the read queue

Ports:
- clk  in  1  clock; all logic on posedge
- rstn  in  1  **synchronous, active-low reset**
- awvalid, awready, arvalid, arready, wvalid, wready, wlast, bvalid, bready, rvalid, rready, rlast  in  1 each  channel handshake/last
- awaddr, araddr  in  ADDR_W  addresses (stability check only)
- awid, arid, bid, rid  in  ID_W  IDs
- awlen, arlen  in  LEN_W  burst lengths
- err  out  8  sticky error vector; bit indices in package
- first_err  out  3  index of the first error raised
- err_any  out  1  OR of err
- wr_done_cnt, rd_done_cnt  out  32  completed writes (B handshakes), completed reads (RLAST handshakes)
- wr_outst, rd_outst  out  $clog2(MAX_OUTST)+1  AW-accepted-but-not-B-completed bursts; AR-accepted-but-not-RLAST bursts

## Operation
- Handshake = valid & ready sampled on the same edge.
- **Write path**
  - AW handshake pushes awlen into a write-length FIFO.
  - Each W handshake increments a beat counter against the head length.
  - The beat with count == head len must have wlast=1. That beat pops the FIFO, clears the counter and increments b_pending.
  - If wlast differs from (count == head len), raise ERR_WLAST. The FIFO still pops when wlast=1, to resynchronise.
- **W before AW**
  - A W handshake is legal when the FIFO is non-empty or an AW handshake occurs in the same cycle (bypass).
  - Otherwise raise ERR_W_NO_AW and ignore the beat.
- **B response**: a B handshake with b_pending==0, not counting a WLAST handshake in the same cycle, raises ERR_B_NO_W. Otherwise b_pending decrements and wr_done_cnt increments.
- **Read path**
  - AR handshake pushes {arid, arlen} into a read FIFO.
  - R beats are counted against the head entry. RLAST is checked exactly as WLAST and raises ERR_RLAST.
  - An R handshake with an empty FIFO raises ERR_R_NO_AR.
  - If RID_CHECK=1 and rid ≠ head id, raise ERR_RID.
- **Stability**: if VALID was 1 and READY was 0 on the previous edge, then on the current edge:
  - VALID must still be 1.
  - For AW and AR, addr/id/len must be unchanged.
  - Any violation on any channel raises ERR_STABLE.
- **Overflow**: an AW or AR handshake while its FIFO holds MAX_OUTST entries raises ERR_OVF and drops the push.
- **Error latching**
  - err bits are sticky until reset.
  - first_err latches only while err==0. If several bits are raised in one cycle, the lowest index wins.
- Counters wrap modulo 2^32.
- Reset values: err=0, first_err=0, err_any=0, all counters 0, FIFOs empty, beat counters 0, stability history cleared.

## Timing
- All outputs are registered. An error sampled on edge N is visible after edge N, i.e. one cycle of latency.
- Simultaneous AW and W handshakes on an empty FIFO: the beat is counted against the new awlen, and a single-beat burst with wlast pops it in the same cycle.
- Simultaneous push and pop on a full FIFO is legal and raises no ERR_OVF.
- wr_outst: +1 on AW handshake, −1 on B handshake; net 0 when both occur in the same cycle.
- rd_outst: +1 on AR handshake, −1 on RLAST handshake; net 0 when both occur in the same cycle.
- rstn low on any edge clears all state at that edge, including mid-burst. Beats in flight are forgotten, and the first post-reset W beat with no AW raises ERR_W_NO_AW.

## Structure
- Package axi_chk_pkg holds:
  - error index localparams: ERR_WLAST=0, ERR_W_NO_AW=1, ERR_B_NO_W=2, ERR_RLAST=3, ERR_R_NO_AR=4, ERR_RID=5, ERR_STABLE=6, ERR_OVF=7
  - the packed struct type for read-FIFO entries {id, len}
- One sub-module, axi_chk_fifo: a parametrised synchronous FIFO with width and depth parameters, exposing full/empty, head data and a same-cycle push+pop path. It is instantiated twice, for write lengths and read entries.

## Test plan
- AW len=3 then 4 W beats with wlast on the 4th, then B → err=0, wr_done_cnt=1, wr_outst returns to 0.
- AW len=1 then 2 W beats with no wlast on the 2nd → err[0]=1, first_err=0, one cycle after the 2nd beat.
- AR id=5 len=0, then R beat with rid=3, rlast=1, RID_CHECK=1 → err[5]=1; rd_done_cnt=1.
- awvalid=1, awready=0 for 2 cycles, awaddr changed in cycle 2 → err[6]=1.
- 9 AR handshakes with no R (MAX_OUTST=8) → err[7]=1, rd_outst=8.
- B handshake with no prior write; rstn pulsed low for one cycle mid-burst → err[2]=1; after reset all outputs are 0.
